// File: rtl/signed_delta_pkg.sv
// Shared types and constants for the signed delta decoder.
package signed_delta_pkg;

  // Default reconstructed sample width and dropped-beat counter width.
  localparam int DATA_W_DEF = 4;
  localparam int DROP_W_DEF = 8;

  // Lower clamp bound for a reconstructed sample.
  localparam int CLAMP_MIN = 0;

  // Accumulator seeding state: UNLOCKED until the first sync beat.
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Signed difference width: one bit wider than the sample.
  function automatic int diff_width(input int w);
    return w + 1;
  endfunction

  // Upper clamp bound for a w-bit unsigned sample.
  function automatic int clamp_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/signed_delta_clamp.sv
// Combinational accumulator + signed difference with saturation to the
// unsigned sample range; err flags any clamped result.
module signed_delta_clamp
  import signed_delta_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W:0]   diff,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(clamp_max(DATA_W));
  localparam logic [DATA_W-1:0] MIN_V = DATA_W'(CLAMP_MIN);

  // Two guard bits: the top one is the sign, the next one flags overflow.
  logic [DATA_W+1:0] sum;

  // Zero-extended acc plus sign-extended diff, then saturate.
  always_comb begin
    sum    = {2'b00, acc} + {diff[DATA_W], diff};
    result = sum[DATA_W-1:0];
    err    = 1'b0;
    if (sum[DATA_W+1]) begin
      result = MIN_V;
      err    = 1'b1;
    end else if (sum[DATA_W]) begin
      result = MAX_V;
      err    = 1'b1;
    end
  end

endmodule

// File: rtl/signed_delta_decoder.sv
// Rebuilds absolute unsigned samples from a stream of signed differences.
// Sync beats (re)seed the accumulator; diff beats before the first sync are
// discarded and counted.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high.
// Both pipeline stages advance together when adv = !outVld | outRdy, and
// inRdy = adv while out of reset. Once outVld is high, sampleOut and errOut
// hold until outRdy.
module signed_delta_decoder
  import signed_delta_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inVld,
  output logic              inRdy,
  input  logic              syncIn,
  input  logic [DATA_W-1:0] sampleIn,
  input  logic [DATA_W:0]   diffIn,
  output logic              outVld,
  input  logic              outRdy,
  output logic [DATA_W-1:0] sampleOut,
  output logic              errOut,
  output logic              lockedOut,
  output logic [DROP_W-1:0] dropCntOut
);

  localparam int DIFF_W = diff_width(DATA_W);

  logic              adv;
  logic              s1_vld;
  logic              s1_sync;
  logic [DATA_W-1:0] s1_sample;
  logic [DIFF_W-1:0] s1_diff;
  logic [DATA_W-1:0] acc;
  state_t            state;
  logic [DATA_W-1:0] sum_clamped;
  logic              sum_err;

  assign adv       = !outVld || outRdy;
  assign inRdy     = adv && rst_n;
  assign lockedOut = (state == ST_LOCKED);

  signed_delta_clamp #(.DATA_W(DATA_W)) u_clamp (
    .acc    (acc),
    .diff   (s1_diff),
    .result (sum_clamped),
    .err    (sum_err)
  );

  // Stage 1: capture the accepted beat; hold it while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_sync   <= 1'b0;
      s1_sample <= '0;
      s1_diff   <= '0;
    end else if (adv) begin
      s1_vld <= inVld;
      if (inVld) begin
        s1_sync   <= syncIn;
        s1_sample <= sampleIn;
        s1_diff   <= diffIn;
      end
    end
  end

  // Stage 2: FSM, accumulator update, registered output and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_UNLOCKED;
      acc        <= '0;
      outVld     <= 1'b0;
      sampleOut  <= '0;
      errOut     <= 1'b0;
      dropCntOut <= '0;
    end else if (adv) begin
      outVld <= 1'b0;
      if (s1_vld) begin
        if (s1_sync) begin
          state     <= ST_LOCKED;
          acc       <= s1_sample;
          sampleOut <= s1_sample;
          errOut    <= 1'b0;
          outVld    <= 1'b1;
        end else if (state == ST_LOCKED) begin
          acc       <= sum_clamped;
          sampleOut <= sum_clamped;
          errOut    <= sum_err;
          outVld    <= 1'b1;
        end else if (dropCntOut != {DROP_W{1'b1}}) begin
          // Unseeded diff: swallowed, only counted (saturating).
          dropCntOut <= dropCntOut + DROP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_delta_decoder.sv
// Bench for signed_delta_decoder: vector table, directed corner sequences,
// and a random stream against a small reference model.
module tb_signed_delta_decoder;

  localparam int DATA_W = 4;
  localparam int DROP_W = 8;
  localparam int EW     = DATA_W + 1;

  logic              clk;
  logic              rst_n;
  logic              inVld;
  logic              inRdy;
  logic              syncIn;
  logic [DATA_W-1:0] sampleIn;
  logic [DATA_W:0]   diffIn;
  logic              outVld;
  logic              outRdy;
  logic [DATA_W-1:0] sampleOut;
  logic              errOut;
  logic              lockedOut;
  logic [DROP_W-1:0] dropCntOut;

  signed_delta_decoder #(.DATA_W(DATA_W), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inVld      (inVld),
    .inRdy      (inRdy),
    .syncIn     (syncIn),
    .sampleIn   (sampleIn),
    .diffIn     (diffIn),
    .outVld     (outVld),
    .outRdy     (outRdy),
    .sampleOut  (sampleOut),
    .errOut     (errOut),
    .lockedOut  (lockedOut),
    .dropCntOut (dropCntOut)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {err, sample}
  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int m_acc    = 0;
  bit m_locked = 0;
  int m_drops  = 0;

  // Output ready control
  bit rand_rdy       = 0;
  int stall_left     = 0;
  bit stall_on_first = 0;

  typedef struct {
    bit                sync;
    logic [DATA_W-1:0] sample;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] exp_s;
    bit                exp_e;
  } vec_t;

  vec_t tab[20];
  int   n_tab = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input bit s, input logic [DATA_W-1:0] smp, input logic [DATA_W:0] d,
                         input logic [DATA_W-1:0] es, input bit ee);
    tab[n_tab].sync   = s;
    tab[n_tab].sample = smp;
    tab[n_tab].diff   = d;
    tab[n_tab].exp_s  = es;
    tab[n_tab].exp_e  = ee;
    n_tab++;
  endtask

  // Reference: returns 1 and the expected {err,sample} if the beat produces output.
  function automatic bit model_step(input bit s, input logic [DATA_W-1:0] smp,
                                    input logic [DATA_W:0] d, output logic [EW-1:0] res);
    int sd;
    int sum;
    res = '0;
    if (s) begin
      m_acc    = int'(smp);
      m_locked = 1;
      res      = {1'b0, smp};
      return 1;
    end
    if (!m_locked) begin
      if (m_drops < 255) m_drops++;
      return 0;
    end
    sd  = d[DATA_W] ? int'(d) - 32 : int'(d);
    sum = m_acc + sd;
    if (sum < 0)       begin m_acc = 0;  res = {1'b1, 4'd0};  end
    else if (sum > 15) begin m_acc = 15; res = {1'b1, 4'd15}; end
    else               begin m_acc = sum; res = {1'b0, 4'(sum)}; end
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Offer one beat until accepted; push an expectation when it is.
  task automatic send(input bit s, input logic [DATA_W-1:0] smp, input logic [DATA_W:0] d,
                      input bit use_tab, input logic [DATA_W-1:0] es, input bit ee);
    logic [EW-1:0] r;
    bit            has;
    int            tries = 0;
    bit            done  = 0;
    while (!done) begin
      @(negedge clk);
      inVld    = 1'b1;
      syncIn   = s;
      sampleIn = smp;
      diffIn   = d;
      #4;
      if (inRdy) begin
        has = model_step(s, smp, d, r);
        if (use_tab) exp_q.push_back({ee, es});
        else if (has) exp_q.push_back(r);
        done = 1;
      end else begin
        tries++;
        if (tries > 200) begin
          check("accept_timeout", 32'(tries), 0);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    inVld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    repeat (3) @(negedge clk);
    while ((exp_q.size() != 0 || outVld) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    inVld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_outVld",  32'(outVld), 0);
    check("rst_inRdy",   32'(inRdy), 0);
    check("rst_sample",  32'(sampleOut), 0);
    check("rst_err",     32'(errOut), 0);
    check("rst_locked",  32'(lockedOut), 0);
    check("rst_dropcnt", 32'(dropCntOut), 0);
    exp_q.delete();
    m_acc = 0; m_locked = 0; m_drops = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    outRdy = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        outRdy = 1'b0;
        stall_left--;
      end else if (rand_rdy) outRdy = 1'($urandom_range(0, 1));
      else outRdy = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    bit            hold_vld = 0;
    logic [EW-1:0] hold_v   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        hold_vld = 0;
      end else if (outVld) begin
        if (hold_vld) check("hold_stable", 32'({errOut, sampleOut}), 32'(hold_v));
        if (outRdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'({errOut, sampleOut}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sample", 32'(sampleOut), 32'(e[DATA_W-1:0]));
            check("err",    32'(errOut),    32'(e[DATA_W]));
          end
          hold_vld = 0;
          if (stall_on_first) begin
            stall_on_first = 0;
            stall_left     = 3;
          end
        end else begin
          check("stall_inRdy", 32'(inRdy), 0);
          hold_vld = 1;
          hold_v   = {errOut, sampleOut};
        end
      end else begin
        if (hold_vld) check("vld_dropped", 32'(outVld), 1);
        hold_vld = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    rst_n    = 1'b1;
    inVld    = 1'b0;
    syncIn   = 1'b0;
    sampleIn = '0;
    diffIn   = '0;
    #2;
    do_reset();

    // Diffs before any sync are dropped and counted.
    send(0, 4'd0, 5'd1, 0, 4'd0, 0);
    send(0, 4'd0, 5'd1, 0, 4'd0, 0);
    send(0, 4'd0, 5'd1, 0, 4'd0, 0);
    drain();
    check("t2_dropcnt", 32'(dropCntOut), 3);
    check("t2_locked",  32'(lockedOut), 0);
    send(1, 4'd0, 5'd0, 1, 4'd0, 0);
    drain();
    check("t2_locked_after_sync", 32'(lockedOut), 1);

    // Vector table: basic reconstruction, clamping, reseeding.
    add_vec(1, 4'd5,  5'd0,  4'd5,  0);
    add_vec(0, 4'd0,  5'd3,  4'd8,  0);
    add_vec(0, 4'd0,  5'h1E, 4'd6,  0);   // -2
    add_vec(0, 4'd0,  5'd10, 4'd15, 1);   // 16 -> clamp high
    add_vec(1, 4'd2,  5'd0,  4'd2,  0);
    add_vec(0, 4'd0,  5'h1B, 4'd0,  1);   // -5 -> clamp low
    add_vec(0, 4'd0,  5'h10, 4'd0,  1);   // -16 -> clamp low
    add_vec(0, 4'd0,  5'h0F, 4'd15, 0);   // +15 exactly max
    add_vec(1, 4'd9,  5'd0,  4'd9,  0);
    add_vec(1, 4'd1,  5'd0,  4'd1,  0);   // reseed while locked
    add_vec(0, 4'd0,  5'd1,  4'd2,  0);
    add_vec(0, 4'd0,  5'h10, 4'd0,  1);   // 2-16
    add_vec(0, 4'd0,  5'h0F, 4'd15, 0);
    add_vec(0, 4'd0,  5'd1,  4'd15, 1);   // 16 -> clamp high
    add_vec(0, 4'd0,  5'h1F, 4'd14, 0);   // -1
    add_vec(1, 4'd3,  5'h0F, 4'd3,  0);   // diff field ignored on sync
    add_vec(0, 4'd12, 5'd2,  4'd5,  0);   // sample field ignored on diff
    for (int i = 0; i < n_tab; i++)
      send(tab[i].sync, tab[i].sample, tab[i].diff, 1, tab[i].exp_s, tab[i].exp_e);
    drain();
    check("tab_dropcnt", 32'(dropCntOut), 3);

    // Backpressure: 3-cycle stall right after the first output.
    stall_on_first = 1;
    send(1, 4'd0, 5'd0, 1, 4'd0, 0);
    for (int i = 1; i <= 4; i++) send(0, 4'd0, 5'd1, 1, 4'(i), 0);
    drain();
    check("t4_stall_consumed", 32'(stall_on_first), 0);

    // Reset with two beats in flight.
    send(1, 4'd3, 5'd0, 1, 4'd3, 0);
    send(0, 4'd0, 5'd1, 1, 4'd4, 0);
    do_reset();
    send(0, 4'd0, 5'd4, 0, 4'd0, 0);
    drain();
    check("t6_dropcnt", 32'(dropCntOut), 1);
    check("t6_locked",  32'(lockedOut), 0);
    send(1, 4'd7, 5'd0, 1, 4'd7, 0);
    drain();
    check("t6_locked_after", 32'(lockedOut), 1);

    // Random stream against the model with random output ready.
    do_reset();
    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      bit                s;
      logic [DATA_W-1:0] smp;
      logic [DATA_W:0]   d;
      s   = ($urandom_range(0, 7) == 0);
      smp = 4'($urandom_range(0, 15));
      d   = 5'($urandom_range(0, 31));
      send(s, smp, d, 0, 4'd0, 0);
      if ($urandom_range(0, 9) == 0) idle();
    end
    drain();
    rand_rdy = 0;
    check("rand_dropcnt", 32'(dropCntOut), 32'(m_drops));
    check("rand_locked",  32'(lockedOut), 32'(m_locked));
    check("rand_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
